// File: rtl/parking_sensor_filter_pkg.sv
// parking_pkg: shared constants for the parking-lot sensor front end and car counter
package parking_pkg;
  localparam int PARK_DEBOUNCE_CYCLES = 4;
  localparam int PARK_STUCK_CYCLES = 1024;
  localparam int SENS_A = 0;
  localparam int SENS_B = 1;
  localparam int PARK_COUNT_W = 3;
  typedef logic [1:0] sens_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/parking_sensor_filter_if.sv
// parking_sensor_filter_if: raw photo-sensor lines in, filtered levels and stuck flag out
interface parking_sensor_filter_if;
  logic a_raw, b_raw, a, b, fault;
  modport master(output a_raw, b_raw, input a, b, fault);
  modport slave(input a_raw, b_raw, output a, b, fault);
endinterface

// File: rtl/parking_sensor_filter_debounce.sv
// sensor_debounce: two-flop synchroniser and stability counter for one sensor channel
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PARK_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic grant,
  output logic ready,
  output logic level
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  assign ready = (s2 != level) && (cnt == LAST);
  // a ready channel without grant keeps cnt so it can commit on the next edge
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (!ready) cnt <= cnt + 1'b1;
      else if (grant) begin
        level <= s2;
        cnt <= '0;
      end
    end
endmodule

// File: rtl/parking_sensor_filter.sv
// parking_sensor_filter: debounced a/b levels that change one at a time, plus sticky stuck-sensor fault
module parking_sensor_filter
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PARK_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES = PARK_STUCK_CYCLES
) (
  input logic clk,
  input logic reset,
  parking_sensor_filter_if.slave s
);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STK_MAX = SW'(STUCK_CYCLES);
  sens_t raw, grant, ready, level;
  logic [SW-1:0] stk;
  logic fault;
  // a wins a tie so the counter never sees both lines change on one edge
  always_comb begin
    raw = '0;
    grant = '0;
    raw[SENS_A] = s.a_raw;
    raw[SENS_B] = s.b_raw;
    grant[SENS_A] = 1'b1;
    grant[SENS_B] = ~ready[SENS_A];
  end
  for (genvar i = 0; i < 2; i++) begin : g_ch
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .reset(reset),
      .raw(raw[i]),
      .grant(grant[i]),
      .ready(ready[i]),
      .level(level[i])
    );
  end
  always_ff @(posedge clk)
    if (reset) begin
      stk <= '0;
      fault <= 1'b0;
    end else begin
      stk <= !(|level) ? '0 : stk == STK_MAX ? stk : stk + 1'b1;
      fault <= fault | ((|level) && stk == STK_MAX - 1'b1);
    end
  assign s.a = level[SENS_A];
  assign s.b = level[SENS_B];
  assign s.fault = fault;
endmodule
